decode_stage: RTL and testbench

Decode stage of the five-stage RISC-V pipeline. It consumes the fetch→decode pipeline register (`if_id_type`), decodes R-type and I-type ALU instructions, and reads two operands from an internal 32×32 register file that has a write-back port. It then drives the decode→execute register (`id_ex_type` plus control) through a valid/ready handshake, with stall and flush support.

---
 rtl/common.sv | 53 +++++
 rtl/register_file.sv | 35 +++
 rtl/decode_stage.sv | 94 +++++++++
 tb/tb_decode_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// common: shared pipeline types, ALU encodings and instruction-field constants
package common;

    localparam int XLEN_C = 32;
    localparam int PC_W   = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110
    } alu_op_type;

    localparam logic [6:0] OP_REG  = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_OR   = 3'b110;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_type;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        instruction_type instruction;
    } if_id_type;

    typedef struct packed {
        logic [XLEN_C-1:0] data1;
        logic [XLEN_C-1:0] data2;
    } id_ex_type;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        alu_op_type      alu_op;
        logic            reg_write;
    } id_ex_ctrl_type;

    // I-type immediate lives in funct7:rs2, i.e. instruction[31:20]
    function automatic logic [XLEN_C-1:0] imm_i(input instruction_type i);
        return {{20{i.funct7[6]}}, i.funct7, i.rs2};
    endfunction

endpackage

// File: rtl/register_file.sv
// register_file: 32x32 registers, two combinational reads, one write with same-cycle bypass
module register_file
    import common::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    logic [XLEN-1:0] regs [32];

    // x0 is hardwired zero; a write landing this cycle is forwarded to the reader
    always_comb begin
        rd1 = rs1 == 5'd0 ? '0 : (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
        rd2 = rs2 == 5'd0 ? '0 : (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];
    end

    // clear all registers on reset, otherwise commit write-back (x0 never written)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes R/I-type ALU ops, reads operands and registers the decode->execute stage
module decode_stage
    import common::*;
#(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_id_valid,
    input  if_id_type       if_id,
    output logic            if_id_ready,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            id_ex_valid,
    output id_ex_type       id_ex,
    output id_ex_ctrl_type  id_ex_ctrl,
    output logic            illegal
);

    instruction_type inst;
    logic [PC_WIDTH-1:0] pc;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic legal, accept;
    alu_op_type alu_op;

    assign inst        = if_id.instruction;
    assign pc          = if_id.pc;
    assign if_id_ready = !id_ex_valid || ex_ready;
    assign accept      = if_id_valid && if_id_ready;

    register_file #(.XLEN(XLEN)) u_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .rs1     (inst.rs1),
        .rs2     (inst.rs2),
        .rd1     (rs1_val),
        .rd2     (rs2_val),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .wb_data (wb_data)
    );

    // map opcode/funct fields to an ALU operation; anything unlisted is illegal
    always_comb begin
        legal  = 1'b0;
        alu_op = ALU_ADD;
        if (inst.opcode == OP_REG) begin
            case ({inst.funct7, inst.funct3})
                {F7_BASE, F3_ADD}: begin legal = 1'b1; alu_op = ALU_ADD; end
                {F7_SUB,  F3_ADD}: begin legal = 1'b1; alu_op = ALU_SUB; end
                {F7_BASE, F3_AND}: begin legal = 1'b1; alu_op = ALU_AND; end
                {F7_BASE, F3_OR }: begin legal = 1'b1; alu_op = ALU_OR;  end
                default: ;
            endcase
        end else if (inst.opcode == OP_IMM) begin
            case (inst.funct3)
                F3_ADD:  begin legal = 1'b1; alu_op = ALU_ADD; end
                F3_AND:  begin legal = 1'b1; alu_op = ALU_AND; end
                F3_OR:   begin legal = 1'b1; alu_op = ALU_OR;  end
                default: ;
            endcase
        end
    end

    // output register: reset > flush > load > drain > hold
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            id_ex_valid <= 1'b0;
            illegal     <= 1'b0;
            id_ex       <= '0;
            id_ex_ctrl  <= '0;
        end else begin
            illegal <= accept && !legal && !flush;
            if (flush) begin
                id_ex_valid <= 1'b0;
            end else if (accept && legal) begin
                id_ex_valid          <= 1'b1;
                id_ex.data1          <= rs1_val;
                id_ex.data2          <= inst.opcode == OP_IMM ? imm_i(inst) : rs2_val;
                id_ex_ctrl.pc        <= pc;
                id_ex_ctrl.rd        <= inst.rd;
                id_ex_ctrl.alu_op    <= alu_op;
                id_ex_ctrl.reg_write <= 1'b1;
            end else if (ex_ready) begin
                id_ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed plus random stimulus checked against a behavioural decode model
module tb_decode_stage;
    import common::*;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           if_id_valid;
    if_id_type      if_id;
    logic           if_id_ready;
    logic           wb_en;
    logic [4:0]     wb_rd;
    logic [31:0]    wb_data;
    logic           flush;
    logic           ex_ready;
    logic           id_ex_valid;
    id_ex_type      id_ex;
    id_ex_ctrl_type id_ex_ctrl;
    logic           illegal;

    decode_stage #(.XLEN(32), .PC_WIDTH(5)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .if_id_valid (if_id_valid),
        .if_id       (if_id),
        .if_id_ready (if_id_ready),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flush       (flush),
        .ex_ready    (ex_ready),
        .id_ex_valid (id_ex_valid),
        .id_ex       (id_ex),
        .id_ex_ctrl  (id_ex_ctrl),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [31:0] m_reg [32];
    logic        m_valid = 1'b0;
    logic        m_ill   = 1'b0;
    logic [31:0] m_d1 = '0, m_d2 = '0;
    logic [2:0]  m_op = '0;
    logic [4:0]  m_rd = '0, m_pc = '0;
    logic        m_rw = 1'b0;
    logic [4:0]  pc_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // ALU codes: and=0 or=1 add=2 sub=6
    function automatic void ref_decode(input logic [31:0] ins, output logic lg,
                                       output logic [2:0] op, output logic imm);
        int opc, f3, f7;
        opc = int'(ins & 32'h7F);
        f3  = int'((ins >> 12) & 32'h7);
        f7  = int'(ins >> 25);
        lg = 1'b0; op = 3'd0; imm = 1'b0;
        if (opc == 'h33) begin
            if (f3 == 0 && f7 == 0)       begin lg = 1'b1; op = 3'd2; end
            else if (f3 == 0 && f7 == 32) begin lg = 1'b1; op = 3'd6; end
            else if (f3 == 7 && f7 == 0)  begin lg = 1'b1; op = 3'd0; end
            else if (f3 == 6 && f7 == 0)  begin lg = 1'b1; op = 3'd1; end
        end else if (opc == 'h13) begin
            imm = 1'b1;
            if (f3 == 0)      begin lg = 1'b1; op = 3'd2; end
            else if (f3 == 7) begin lg = 1'b1; op = 3'd0; end
            else if (f3 == 6) begin lg = 1'b1; op = 3'd1; end
        end
    endfunction

    function automatic logic [31:0] ref_read(input int r, input logic we, input int wr,
                                             input logic [31:0] wd);
        if (r == 0) return 32'd0;
        if (we && wr == r) return wd;
        return m_reg[r];
    endfunction

    function automatic logic [31:0] r_ins(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
             | (32'(rd) << 7) | 32'h33;
    endfunction

    function automatic logic [31:0] i_ins(input int imm, input int rs1, input int f3, input int rd);
        return (32'(imm & 'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h13;
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic we, input logic [4:0] wr,
                        input logic [31:0] wd, input logic fl, input logic exr, input logic rn);
        logic lg, imm, acc;
        logic [2:0] op;
        logic [31:0] a, b;
        if_id_valid = v;
        if_id.instruction = ins;
        if_id.pc = pc_cnt;
        wb_en = we; wb_rd = wr; wb_data = wd;
        flush = fl; ex_ready = exr; reset_n = rn;
        #1;
        chk("if_id_ready", 32'(if_id_ready), 32'(!m_valid || exr));
        ref_decode(ins, lg, op, imm);
        a = ref_read(int'(ins[19:15]), we, int'(wr), wd);
        b = imm ? 32'($signed(ins) >>> 20) : ref_read(int'(ins[24:20]), we, int'(wr), wd);
        acc = v && (!m_valid || exr);
        @(posedge clk);
        if (!rn) begin
            m_valid = 0; m_ill = 0; m_d1 = 0; m_d2 = 0; m_op = 0; m_rd = 0; m_pc = 0; m_rw = 0;
            for (int i = 0; i < 32; i++) m_reg[i] = '0;
        end else begin
            m_ill = acc && !lg && !fl;
            if (fl) m_valid = 0;
            else if (acc && lg) begin
                m_valid = 1; m_d1 = a; m_d2 = b; m_op = op; m_rd = ins[11:7]; m_pc = pc_cnt; m_rw = 1;
            end else if (exr) m_valid = 0;
            if (we && wr != 0) m_reg[wr] = wd;
        end
        pc_cnt++;
        #1;
        chk("id_ex_valid", 32'(id_ex_valid), 32'(m_valid));
        chk("illegal", 32'(illegal), 32'(m_ill));
        if (m_valid || !rn) begin
            chk("data1", id_ex.data1, m_d1);
            chk("data2", id_ex.data2, m_d2);
            chk("alu_op", 32'(id_ex_ctrl.alu_op), 32'(m_op));
            chk("rd", 32'(id_ex_ctrl.rd), 32'(m_rd));
            chk("pc", 32'(id_ex_ctrl.pc), 32'(m_pc));
            chk("reg_write", 32'(id_ex_ctrl.reg_write), 32'(m_rw));
        end
    endtask

    function automatic logic [31:0] rand_ins();
        int k, f3, f7;
        k  = int'($urandom_range(0, 9));
        f3 = int'($urandom_range(0, 3));
        f3 = f3 == 0 ? 0 : f3 == 1 ? 7 : f3 == 2 ? 6 : int'($urandom_range(0, 7));
        f7 = int'($urandom_range(0, 5));
        f7 = f7 < 3 ? 0 : f7 < 5 ? 32 : int'($urandom_range(0, 127));
        if (k < 5) return r_ins(f7, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), f3,
                                int'($urandom_range(0, 31)));
        if (k < 9) return i_ins(int'($urandom_range(0, 4095)), int'($urandom_range(0, 7)), f3,
                                int'($urandom_range(0, 31)));
        return $urandom;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        // reset
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("ready_after_reset", 32'(if_id_ready), 32'd1);
        // write-back x5, x6 then sub x7,x5,x6
        step(0, 0, 1, 5, 32'h10, 0, 1, 1);
        step(0, 0, 1, 6, 32'h3, 0, 1, 1);
        step(1, r_ins(32, 6, 5, 0, 7), 0, 0, 0, 0, 1, 1);
        chk("sub_data1", id_ex.data1, 32'h10);
        chk("sub_data2", id_ex.data2, 32'h3);
        chk("sub_op", 32'(id_ex_ctrl.alu_op), 32'd6);
        chk("sub_rd", 32'(id_ex_ctrl.rd), 32'd7);
        // addi x1,x0,-1
        step(1, i_ins('hFFF, 0, 0, 1), 0, 0, 0, 0, 1, 1);
        chk("addi_data1", id_ex.data1, 32'h0);
        chk("addi_data2", id_ex.data2, 32'hFFFF_FFFF);
        chk("addi_op", 32'(id_ex_ctrl.alu_op), 32'd2);
        // bypass: or x2,x9,x0 with simultaneous write of x9
        step(1, r_ins(0, 0, 9, 6, 2), 1, 9, 32'hDEAD_BEEF, 0, 1, 1);
        chk("bypass_data1", id_ex.data1, 32'hDEAD_BEEF);
        // write x0 ignored
        step(0, 0, 1, 0, 32'h1234, 0, 1, 1);
        step(1, r_ins(0, 0, 0, 0, 3), 0, 0, 0, 0, 1, 1);
        chk("x0_read", id_ex.data1, 32'h0);
        // stall: hold add x4,x5,x6 for 3 cycles, write x5 meanwhile
        step(1, r_ins(0, 6, 5, 0, 4), 0, 0, 0, 0, 1, 1);
        step(1, i_ins(5, 1, 7, 8), 0, 0, 0, 0, 0, 1);
        step(1, i_ins(5, 1, 7, 8), 1, 5, 32'h99, 0, 0, 1);
        step(1, i_ins(5, 1, 7, 8), 0, 0, 0, 0, 0, 1);
        chk("stall_ready", 32'(if_id_ready), 32'd0);
        chk("stall_held_data1", id_ex.data1, 32'h10);
        step(1, i_ins(5, 1, 7, 8), 0, 0, 0, 0, 1, 1);
        chk("after_stall_rd", 32'(id_ex_ctrl.rd), 32'd8);
        // flush with accept
        step(1, r_ins(0, 2, 1, 0, 3), 0, 0, 0, 1, 1, 1);
        chk("flush_valid", 32'(id_ex_valid), 32'd0);
        // illegal pulse
        step(1, 32'h0, 0, 0, 0, 0, 1, 1);
        chk("illegal_pulse", 32'(illegal), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        chk("illegal_clear", 32'(illegal), 32'd0);
        // reset while holding
        step(1, i_ins(7, 5, 0, 9), 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_valid", 32'(id_ex_valid), 32'd0);
        chk("reset_data1", id_ex.data1, 32'd0);
        // random traffic
        for (int n = 0; n < 500; n++)
            step(1'($urandom_range(0, 3) != 0), rand_ins(), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 59) != 0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
